serial_pixel_transmitter: RTL
=============================

# serial_pixel_transmitter

Frame transmitter for the two-wire pixel link that feeds the network's input shift register. Given a start pulse, it fetches `numInputs` pixels of `dataWidth` bits from a synchronous pixel memory and shifts them out as a serial clock and data pair, MSB first, pixel 0 first. It is the driving end of that link: a loopback/self-test source inside the FPGA, or the same RTL running in a companion device. One frame per `start`; `done` pulses when the last bit has been clocked out.

## Interface
Parameters:
- `numInputs`, 784, pixels per frame.
- `dataWidth`, 16, bits per pixel (Q8.8 value, sent raw).
- `clkDiv`, 25, CLOCK_50 cycles per serialClock half-period; must be ≥ 1.
- `addrWidth`, $clog2(numInputs), pixel address width.

Ports:
- `CLOCK_50`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  single-cycle request to send one frame; ignored unless idle.
- `pixelRd`  out  1  read strobe to pixel memory, one cycle per pixel.
- `pixelAddr`  out  addrWidth  address for `pixelRd`; 0 … numInputs-1.
- `pixelData`  in  dataWidth  memory read data, valid the cycle after `pixelRd`.
- `serialClock`  out  1  link clock; receiver samples on its rising edge.
- `serialData`  out  1  link data; changes only while serialClock is low.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  one-cycle pulse after the final bit's high phase.

## Operation
- States: IDLE, FETCH, LOAD, LOW, HIGH, DONE.
- IDLE: serialClock=0, busy=0. If `start`=1, go to FETCH with pixel index 0.
- FETCH (1 cycle): pixelRd=1, pixelAddr=pixel index. Next state is LOAD.
- LOAD (1 cycle): capture pixelData into the shift register and set bit count to dataWidth-1. Next state is LOW.
- LOW (clkDiv cycles): serialClock=0. On entry, serialData = shift register MSB. Next state is HIGH.
- HIGH (clkDiv cycles): serialClock=1, serialData held. On exit:
  - if bit count > 0: shift left, decrement the count, go to LOW;
  - else if pixel index < numInputs-1: increment the index, go to FETCH;
  - else go to DONE.
- DONE (1 cycle): done=1, busy=1. Next state is IDLE.
- In FETCH and LOAD, serialClock stays 0 and serialData keeps its last value. This stretches the low phase between pixels by 2 cycles, which is harmless to a rising-edge receiver.
- A half-period counter reloads to clkDiv-1 on entry to LOW or HIGH. The state changes when the counter reaches 0.
- `start` is ignored in every state except IDLE; there is no queueing.
- pixelAddr holds its last value outside FETCH.

## Timing
- Reset values: serialClock=0, serialData=0, pixelRd=0, pixelAddr=0, busy=0, done=0, state IDLE, all counters 0.
- Reset has priority over `start` and aborts a frame at any point. The next cycle is IDLE with the reset values, and no `done` is produced.
- For `start` sampled high at edge t:
  - FETCH occupies cycle t+1, with pixelRd=1 and pixelAddr=0;
  - LOAD occupies cycle t+2;
  - the first LOW begins at cycle t+3, with serialData = pixel0[MSB];
  - the first serialClock rise is at t+3+clkDiv.
- Cycles per pixel: 2 + 2·clkDiv·dataWidth.
- Frame length from start to done: numInputs·(2 + 2·clkDiv·dataWidth) + 1 cycles. With the defaults this is 628 769 cycles.
- busy is high in FETCH, LOAD, LOW, HIGH and DONE.
- pixelRd is high exactly numInputs cycles per frame.

## Test plan
- Reset, then idle for 100 cycles. Required: serialClock=0, serialData=0, busy=0, done=0, pixelRd=0 throughout.
- Settings numInputs=2, dataWidth=16, clkDiv=2; memory holds {0xA5C3, 0x0180}; pulse `start`.
  - The bits sampled on the serialClock rises must be 1010010111000011 then 0000000110000000.
  - Exactly 32 rising edges.
  - `done` pulses 1 cycle at start+133.
- Same settings: check that serialData never changes while serialClock=1.
  - pixelRd is asserted at start+1 (addr 0) and at start+67 (addr 1).
- Assert `start` repeatedly during a frame. Required: the frame is unaffected and exactly one `done` is produced. Then a `start` one cycle after `done` begins a new frame with pixelRd at the next cycle.
- Assert reset during bit 5 of pixel 1 while serialClock=1. Required: the next cycle has serialClock=0, busy=0, no `done`; a fresh `start` resends from pixel 0.
- Defaults (784×16, clkDiv=25), transmitter looped back into the network's input shift register, memory holding a known digit. Required:
  - the receiver's buffer equals memory contents after `done`;
  - 12 544 clock rises;
  - frame length 628 769 cycles.

Source files
------------

// File: rtl/serial_pixel_transmitter.sv
// Frame transmitter for the two-wire pixel link: fetches pixels from a synchronous
// memory and shifts them out MSB first as a serial clock/data pair.
module serial_pixel_transmitter #(
  parameter int numInputs = 784,
  parameter int dataWidth = 16,
  parameter int clkDiv    = 25,
  parameter int addrWidth = $clog2(numInputs)
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 start,
  output logic                 pixelRd,
  output logic [addrWidth-1:0] pixelAddr,
  input  logic [dataWidth-1:0] pixelData,
  output logic                 serialClock,
  output logic                 serialData,
  output logic                 busy,
  output logic                 done
);

  localparam int DivW = (clkDiv > 1) ? $clog2(clkDiv) : 1;
  localparam int BitW = (dataWidth > 1) ? $clog2(dataWidth) : 1;

  localparam logic [DivW-1:0]      DivLast = DivW'(clkDiv - 1);
  localparam logic [BitW-1:0]      BitLast = BitW'(dataWidth - 1);
  localparam logic [addrWidth-1:0] PixLast = addrWidth'(numInputs - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t                 state_q;
  logic [DivW-1:0]        div_cnt_q;
  logic [BitW-1:0]        bit_cnt_q;
  logic [addrWidth-1:0]   pix_idx_q;
  logic [dataWidth-1:0]   shift_q;
  logic                   pixel_rd_q;
  logic [addrWidth-1:0]   pixel_addr_q;
  logic                   serial_clock_q;
  logic                   serial_data_q;
  logic                   busy_q;
  logic                   done_q;

  logic [dataWidth-1:0]   shift_d;
  logic [addrWidth-1:0]   pix_idx_d;

  // The next bit appears at the MSB once the register is shifted on a HIGH exit.
  assign shift_d   = shift_q << 1;
  assign pix_idx_d = pix_idx_q + 1'b1;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q        <= IDLE;
      div_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      pix_idx_q      <= '0;
      shift_q        <= '0;
      pixel_rd_q     <= 1'b0;
      pixel_addr_q   <= '0;
      serial_clock_q <= 1'b0;
      serial_data_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= FETCH;
            pix_idx_q    <= '0;
            pixel_rd_q   <= 1'b1;
            pixel_addr_q <= '0;
            busy_q       <= 1'b1;
          end
        end

        FETCH: begin
          pixel_rd_q <= 1'b0;
          state_q    <= LOAD;
        end

        // Memory data for the address presented in FETCH is valid here.
        LOAD: begin
          shift_q       <= pixelData;
          bit_cnt_q     <= BitLast;
          serial_data_q <= pixelData[dataWidth-1];
          div_cnt_q     <= DivLast;
          state_q       <= LOW;
        end

        LOW: begin
          if (div_cnt_q == '0) begin
            serial_clock_q <= 1'b1;
            div_cnt_q      <= DivLast;
            state_q        <= HIGH;
          end else begin
            div_cnt_q <= div_cnt_q - 1'b1;
          end
        end

        HIGH: begin
          if (div_cnt_q == '0) begin
            serial_clock_q <= 1'b0;
            if (bit_cnt_q != '0) begin
              shift_q       <= shift_d;
              serial_data_q <= shift_d[dataWidth-1];
              bit_cnt_q     <= bit_cnt_q - 1'b1;
              div_cnt_q     <= DivLast;
              state_q       <= LOW;
            end else if (pix_idx_q != PixLast) begin
              pix_idx_q    <= pix_idx_d;
              pixel_rd_q   <= 1'b1;
              pixel_addr_q <= pix_idx_d;
              state_q      <= FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            div_cnt_q <= div_cnt_q - 1'b1;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pixelRd     = pixel_rd_q;
  assign pixelAddr   = pixel_addr_q;
  assign serialClock = serial_clock_q;
  assign serialData  = serial_data_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
